imm_field_extractor: RTL and testbench

- Decode-side producer for the immediate path. Takes raw 32-bit RV64 instructions from fetch over a valid/ready handshake.
- Extracts the packed immediate field and classifies it into a shift-op and a width code. These are the inputs the 64-bit immediate expander consumes.
- Presents the result one cycle later on a registered valid/ready output with a one-entry skid buffer, so fetch never stalls combinationally on backpressure.
- Counts illegal opcodes.

---
 rtl/imm_field_extractor_pkg.sv | 58 +++++
 rtl/imm_field_extractor_decode.sv | 60 ++++++
 rtl/imm_field_extractor.sv | 102 ++++++++++
 tb/tb_imm_field_extractor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_field_extractor_pkg.sv
// Shared definitions for the immediate path: opcodes, shift-op and width codes,
// and the decoded-field record. The immediate expander uses the same codes.
package imm_field_extractor_pkg;

   localparam int INST_W = 32;
   localparam int IMM_W  = 20;
   localparam int OPC_W  = 7;

   // RV64 major opcodes recognised by the decoder
   localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OP32     = 7'b0111011;
   localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;

   // How the expander widens the packed field to 64 bits
   typedef enum logic [2:0] {
      SH_NONE   = 3'd0,
      SH_SIGN   = 3'd1,
      SH_UNSIGN = 3'd2,
      SH_ZERO   = 3'd3
   } shift_op_e;

   // Number of meaningful bits in the packed field
   typedef enum logic [1:0] {
      W_20 = 2'd0,
      W_13 = 2'd1,
      W_12 = 2'd2
   } imm_width_e;

   typedef struct packed {
      logic [IMM_W-1:0] imm;
      shift_op_e        shift_op;
      imm_width_e       imm_width;
      logic             half_scaled;
      logic             illegal;
   } imm_dec_t;

   // Record for instructions that carry no immediate
   function automatic imm_dec_t dec_none(input logic illegal);
      imm_dec_t d;
      d.imm         = '0;
      d.shift_op    = SH_NONE;
      d.imm_width   = W_20;
      d.half_scaled = 1'b0;
      d.illegal     = illegal;
      return d;
   endfunction

endpackage

// File: rtl/imm_field_extractor_decode.sv
// Combinational instruction -> packed immediate field classifier.
module imm_field_decode
   import imm_field_extractor_pkg::*;
(
   input  logic [INST_W-1:0] inst,
   output imm_dec_t          dec
);

   logic [OPC_W-1:0] opc;
   assign opc = inst[6:0];

   // Select the field layout by major opcode; everything unknown is illegal
   always_comb begin
      dec = dec_none(1'b0);
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            dec.imm       = inst[31:12];
            dec.shift_op  = SH_ZERO;
            dec.imm_width = W_20;
         end
         OPC_JAL: begin
            // field is offset[20:1]; bit 0 is implicit and restored by the expander
            dec.imm         = {inst[31], inst[19:12], inst[20], inst[30:21]};
            dec.shift_op    = SH_SIGN;
            dec.imm_width   = W_20;
            dec.half_scaled = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
            dec.imm       = {8'd0, inst[31:20]};
            dec.shift_op  = SH_SIGN;
            dec.imm_width = W_12;
         end
         OPC_STORE: begin
            dec.imm       = {8'd0, inst[31:25], inst[11:7]};
            dec.shift_op  = SH_SIGN;
            dec.imm_width = W_12;
         end
         OPC_BRANCH: begin
            dec.imm       = {7'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            dec.shift_op  = SH_SIGN;
            dec.imm_width = W_13;
         end
         OPC_SYSTEM: begin
            // funct3[2] selects the CSR-immediate forms; zimm sits in the rs1 slot
            if (inst[14]) begin
               dec.imm       = {15'd0, inst[19:15]};
               dec.shift_op  = SH_UNSIGN;
               dec.imm_width = W_12;
            end
         end
         OPC_OP, OPC_OP32, OPC_MISC_MEM: begin
            dec = dec_none(1'b0);
         end
         default: begin
            dec = dec_none(1'b1);
         end
      endcase
   end

endmodule

// File: rtl/imm_field_extractor.sv
// Immediate-field producer: decode, registered output with one-entry skid,
// valid/ready on both sides, saturating illegal-opcode counter.
module imm_field_extractor
   import imm_field_extractor_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [19:0]      out_imm,
   output logic [2:0]       out_shift_op,
   output logic [1:0]       out_imm_width,
   output logic             out_half_scaled,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   imm_dec_t        in_dec;
   imm_dec_t        out_d;
   imm_dec_t        skid_d;
   logic [XLEN-1:0] out_pc_q;
   logic [XLEN-1:0] skid_pc;
   logic            out_vld;
   logic            skid_vld;
   logic            acc;
   logic            out_load;
   logic [CNT_W-1:0] cnt;

   imm_field_decode u_dec (
      .inst (in_inst),
      .dec  (in_dec)
   );

   // in_ready comes straight from the skid flop, so fetch never sees out_ready
   assign in_ready = ~skid_vld;
   // inputs presented during a flush are dropped, not accepted
   assign acc      = in_valid & in_ready & ~flush;
   assign out_load = ~out_vld | out_ready;

   // Output register and skid. Accept implies the skid is empty, so the skid
   // only ever drains into the output register and never competes with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_d    <= '0;
         out_pc_q <= '0;
         skid_vld <= 1'b0;
         skid_d   <= '0;
         skid_pc  <= '0;
      end else if (flush) begin
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
      end else if (out_load) begin
         out_vld <= skid_vld | acc;
         if (skid_vld) begin
            out_d    <= skid_d;
            out_pc_q <= skid_pc;
            skid_vld <= acc;
            if (acc) begin
               skid_d  <= in_dec;
               skid_pc <= in_pc;
            end
         end else if (acc) begin
            out_d    <= in_dec;
            out_pc_q <= in_pc;
         end
      end else if (acc) begin
         // output is held: park the new entry behind it
         skid_vld <= 1'b1;
         skid_d   <= in_dec;
         skid_pc  <= in_pc;
      end
   end

   // Count illegal instructions at acceptance; saturate at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (acc && in_dec.illegal && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid       = out_vld;
   assign out_pc          = out_pc_q;
   assign out_imm         = out_d.imm;
   assign out_shift_op    = out_d.shift_op;
   assign out_imm_width   = out_d.imm_width;
   assign out_half_scaled = out_d.half_scaled;
   assign out_illegal     = out_d.illegal;
   assign illegal_cnt     = cnt;

endmodule

// File: tb/tb_imm_field_extractor.sv
// Directed bench for imm_field_extractor with a scoreboard of expected outputs.
module tb_imm_field_extractor;

   localparam int XLEN  = 64;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst, flush, in_valid, out_ready;
   logic             in_ready, out_valid;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc, out_pc;
   logic [19:0]      out_imm;
   logic [2:0]       out_shift_op;
   logic [1:0]       out_imm_width;
   logic             out_half_scaled, out_illegal;
   logic [CNT_W-1:0] illegal_cnt;

   typedef struct {
      logic [63:0] pc;
      logic [19:0] imm;
      logic [2:0]  op;
      logic [1:0]  w;
      logic        hs;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_out = 0;

   always #5 clk = ~clk;

   imm_field_extractor #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_inst         (in_inst),
      .in_pc           (in_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_imm         (out_imm),
      .out_shift_op    (out_shift_op),
      .out_imm_width   (out_imm_width),
      .out_half_scaled (out_half_scaled),
      .out_illegal     (out_illegal),
      .illegal_cnt     (illegal_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every handshake on the output side pops and checks one entry
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pc",   out_pc,          e.pc);
            chk("sb_imm",  out_imm,         e.imm);
            chk("sb_op",   out_shift_op,    e.op);
            chk("sb_w",    out_imm_width,   e.w);
            chk("sb_hs",   out_half_scaled, e.hs);
            chk("sb_ill",  out_illegal,     e.ill);
         end
         n_out++;
      end
      if (rst || flush) sb.delete();
   end

   // Present one instruction until accepted (bounded), then record its expectation
   task automatic send(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [19:0] imm, input logic [2:0] op, input logic [1:0] w,
                       input logic hs, input logic ill);
      bit   ok;
      exp_t e;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_in_time", 64'(ok), 64'd1);
      if (ok) begin
         e.pc = pc; e.imm = imm; e.op = op; e.w = w; e.hs = hs; e.ill = ill;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   int n0;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = '0; in_pc = '0;

      // reset state
      tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_cnt",       illegal_cnt, 0);
      chk("rst_out_imm",   out_imm, 0);
      chk("rst_out_pc",    out_pc, 0);
      tick();
      rst = 1'b0;
      tick();

      // LUI, one-cycle latency
      send(32'h12345037, 64'h1000, 20'h12345, 3'd3, 2'd0, 1'b0, 1'b0);
      chk("lui_valid", out_valid, 1);
      chk("lui_imm",   out_imm, 20'h12345);
      chk("lui_op",    out_shift_op, 3);
      tick();

      // addi then beq back-to-back
      n0 = n_out;
      send(32'hFFF00093, 64'h2000, 20'h00FFF, 3'd1, 2'd2, 1'b0, 1'b0);
      chk("addi_imm",   out_imm, 20'h00FFF);
      chk("b2b_ready",  in_ready, 1);
      send(32'hFE000EE3, 64'h2004, 20'h01FFC, 3'd1, 2'd1, 1'b0, 1'b0);
      chk("beq_imm",    out_imm, 20'h01FFC);
      chk("beq_width",  out_imm_width, 1);
      tick(); tick();
      chk("b2b_count",  64'(n_out - n0), 2);

      // backpressure: A in output, B in skid, C held by fetch
      out_ready = 1'b0;
      send(32'h00812083, 64'h3000, 20'h00008, 3'd1, 2'd2, 1'b0, 1'b0);
      chk("stall_a_valid", out_valid, 1);
      chk("stall_ready_a", in_ready, 1);
      send(32'h00112623, 64'h3004, 20'h0000C, 3'd1, 2'd2, 1'b0, 1'b0);
      chk("stall_skid_full", in_ready, 0);
      chk("stall_a_imm",     out_imm, 20'h00008);
      fork
         send(32'hABCDE297, 64'h3008, 20'hABCDE, 3'd3, 2'd0, 1'b0, 1'b0);
         begin
            repeat (2) @(negedge clk);
            #1;
            chk("stall_hold_ready", in_ready, 0);
            chk("stall_stable_imm", out_imm, 20'h00008);
            chk("stall_stable_pc",  out_pc, 64'h3000);
            @(posedge clk); #1;
            n0 = n_out;
            out_ready = 1'b1;
         end
      join
      @(negedge clk); #1;
      chk("drain_no_gap", 64'(n_out - n0), 3);
      tick();

      // CSR immediate and JAL
      send(32'h3402D073, 64'h4000, 20'h00005, 3'd2, 2'd2, 1'b0, 1'b0);
      chk("csr_op",  out_shift_op, 2);
      send(32'hFFDFF06F, 64'h4004, 20'hFFFFE, 3'd1, 2'd0, 1'b1, 1'b0);
      chk("jal_imm", out_imm, 20'hFFFFE);
      chk("jal_hs",  out_half_scaled, 1);
      tick();

      // flush with skid full: counter retained
      out_ready = 1'b0;
      send(32'hFFFFFFFF, 64'h5000, 20'h0, 3'd0, 2'd0, 1'b0, 1'b1);
      send(32'h00812083, 64'h5004, 20'h00008, 3'd1, 2'd2, 1'b0, 1'b0);
      chk("fl_skid_full", in_ready, 0);
      chk("fl_cnt_before", illegal_cnt, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready",  in_ready, 1);
      chk("fl_cnt_kept",  illegal_cnt, 1);
      out_ready = 1'b1;
      tick();
      chk("fl_stays_empty", out_valid, 0);

      // reset mid-stream: everything cleared including the counter
      out_ready = 1'b0;
      send(32'hFFFFFFFF, 64'h6000, 20'h0, 3'd0, 2'd0, 1'b0, 1'b1);
      send(32'h0000007F, 64'h6004, 20'h0, 3'd0, 2'd0, 1'b0, 1'b1);
      chk("rs_cnt_before", illegal_cnt, 3);
      chk("rs_skid_full",  in_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_out_valid", out_valid, 0);
      chk("rs_in_ready",  in_ready, 1);
      chk("rs_cnt",       illegal_cnt, 0);
      chk("rs_out_imm",   out_imm, 0);
      out_ready = 1'b1;
      tick();

      // saturating counter with CNT_W=2
      for (int k = 0; k < 5; k++) begin
         send(32'hFFFFFFFF, 64'h7000 + 64'(4*k), 20'h0, 3'd0, 2'd0, 1'b0, 1'b1);
         chk("sat_illegal", out_illegal, 1);
         chk("sat_cnt", illegal_cnt, (k < 2) ? k + 1 : 3);
      end
      repeat (3) tick();
      chk("sb_drained", 64'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
